// File: rtl/m_shift_sched_pkg.sv
//------------------------------------------------------------------------------
// m_shift_sched_pkg
//   Shared types and constants for the m_shift_sched round-robin serializer.
//   Contents: FSM state encoding (ST_IDLE / ST_SHIFT) and default sizes.
//   Build option: M_SHIFT_SCHED_MSB_FIRST_EN (used by m_shift_sched only).
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package m_shift_sched_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREQ  = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/m_shift_sched_if.sv
//------------------------------------------------------------------------------
// m_shift_sched_if
//   Bundle between the parallel requesters and the serial scheduler.
//   Signals:
//     w_req   [NREQ]        request per requester, held until granted
//     w_data  [NREQ*WIDTH]  parallel words, requester i at [i*WIDTH +: WIDTH]
//     w_gnt   [NREQ]        one-hot grant pulse (word captured)
//     w_busy, w_valid       high while a word is being shifted out
//     w_sout                serial data bit
//     w_done                one-cycle pulse after the last bit
//   Modports: master (requester side), slave (scheduler side).
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface m_shift_sched_if
  import m_shift_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
);

  logic [NREQ-1:0]       w_req;
  logic [NREQ*WIDTH-1:0] w_data;
  logic [NREQ-1:0]       w_gnt;
  logic                  w_busy;
  logic                  w_valid;
  logic                  w_sout;
  logic                  w_done;

  modport master (
    output w_req, w_data,
    input  w_gnt, w_busy, w_valid, w_sout, w_done
  );

  modport slave (
    input  w_req, w_data,
    output w_gnt, w_busy, w_valid, w_sout, w_done
  );

endinterface

`default_nettype wire

// File: rtl/m_shift_sched_arb.sv
//------------------------------------------------------------------------------
// m_rr_arb
//   Purely combinational round-robin pick. Scans r_ptr, r_ptr+1, ... (mod
//   NREQ) and selects the first active request.
//   Ports:
//     w_req        in  [NREQ]        request vector
//     r_ptr        in  [IW]          current priority pointer (< NREQ)
//     w_win_onehot out [NREQ]        one-hot winner (zero when none)
//     w_win_idx    out [IW]          winner index (zero when none)
//     w_any        out               at least one request active
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module m_rr_arb
  import m_shift_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = $clog2(NREQ)
) (
  input  wire logic [NREQ-1:0] w_req,
  input  wire logic [IW-1:0]   r_ptr,
  output logic      [NREQ-1:0] w_win_onehot,
  output logic      [IW-1:0]   w_win_idx,
  output logic                 w_any
);

  int w_j;

  // Scan from the farthest offset down to offset 0 so the last hit, i.e. the
  // one closest to r_ptr, is the one that sticks.
  always_comb begin
    w_any        = 1'b0;
    w_win_idx    = '0;
    w_win_onehot = '0;
    w_j          = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      w_j = (int'(r_ptr) + off) % NREQ;
      if (w_req[w_j]) begin
        w_any     = 1'b1;
        w_win_idx = IW'(w_j);
      end
    end
    w_win_onehot[w_win_idx] = w_any;
  end

endmodule

`default_nettype wire

// File: rtl/m_shift_sched.sv
//------------------------------------------------------------------------------
// m_shift_sched
//   Round-robin scheduler in front of a shared serial shift register. Grants
//   one requester per IDLE edge, captures its word and shifts it out one bit
//   per clock with a valid strobe, then pulses w_done.
//   Ports:
//     w_clk  in   clock, posedge
//     w_rst  in   synchronous active-high reset
//     bus    slave modport of m_shift_sched_if (req/data in, gnt/busy/valid/
//                 sout/done out)
//   Build option: M_SHIFT_SCHED_MSB_FIRST_EN - defined: MSB first (shift
//   left); undefined: LSB first (shift right).
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module m_shift_sched
  import m_shift_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input wire logic         w_clk,
  input wire logic         w_rst,
  m_shift_sched_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int IW = $clog2(NREQ);

  state_t            r_state;
  logic [WIDTH-1:0]  r_sr;
  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_ptr;
  logic [NREQ-1:0]   r_gnt;
  logic              r_done;

  state_t            w_state_nxt;
  logic [WIDTH-1:0]  w_sr_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [IW-1:0]     w_ptr_nxt;
  logic [NREQ-1:0]   w_gnt_nxt;
  logic              w_done_nxt;

  logic [NREQ-1:0]   w_win_onehot;
  logic [IW-1:0]     w_win_idx;
  logic              w_any;

  m_rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .w_req        (bus.w_req),
    .r_ptr        (r_ptr),
    .w_win_onehot (w_win_onehot),
    .w_win_idx    (w_win_idx),
    .w_any        (w_any)
  );

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state <= ST_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = '0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_sr_nxt    = bus.w_data[int'(w_win_idx)*WIDTH +: WIDTH];
          w_gnt_nxt   = w_win_onehot;
          w_cnt_nxt   = '0;
          // Pointer moves just past the winner so it has lowest priority next.
          w_ptr_nxt   = (w_win_idx == IW'(NREQ - 1)) ? '0 : w_win_idx + IW'(1);
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
`ifdef M_SHIFT_SCHED_MSB_FIRST_EN
        w_sr_nxt  = r_sr << 1;
`else
        w_sr_nxt  = r_sr >> 1;
`endif
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.w_busy  = (r_state == ST_SHIFT);
  assign bus.w_valid = (r_state == ST_SHIFT);
`ifdef M_SHIFT_SCHED_MSB_FIRST_EN
  assign bus.w_sout  = (r_state == ST_SHIFT) ? r_sr[WIDTH-1] : 1'b0;
`else
  assign bus.w_sout  = (r_state == ST_SHIFT) ? r_sr[0] : 1'b0;
`endif
  assign bus.w_gnt   = r_gnt;
  assign bus.w_done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_m_shift_sched.sv
//------------------------------------------------------------------------------
// tb_m_shift_sched
//   Self-checking bench for m_shift_sched (WIDTH=4, NREQ=2). A timeline model
//   schedules, for every grant, the exact cycles of gnt, valid/sout bits and
//   done; one compare process checks the DUT against it every cycle. Directed
//   scenarios add literal expectations, then randomized traffic follows.
//   Build option honoured: M_SHIFT_SCHED_MSB_FIRST_EN.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_m_shift_sched;

  localparam int WIDTH = 4;
  localparam int NREQ  = 2;
  localparam int RING  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  m_shift_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  m_shift_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .w_clk (clk),
    .w_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- timeline model ----------------
  logic [NREQ-1:0]  e_gnt  [RING];
  logic             e_val  [RING];
  logic             e_bit  [RING];
  logic             e_done [RING];
  int               cyc = 0;
  int               free_edge = 0;
  int               m_ptr = 0;
  int               m_win;
  int               m_j;
  logic [WIDTH-1:0] m_word;
  bit               armed = 1'b0;
  logic [4:0]       act_v, exp_v;

  function automatic logic bit_k(input logic [WIDTH-1:0] w, input int k);
`ifdef M_SHIFT_SCHED_MSB_FIRST_EN
    return w[WIDTH-1-k];
`else
    return w[k];
`endif
  endfunction

  initial begin
    for (int i = 0; i < RING; i++) begin
      e_gnt[i] = '0; e_val[i] = 1'b0; e_bit[i] = 1'b0; e_done[i] = 1'b0;
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      armed     = 1'b1;
      m_ptr     = 0;
      free_edge = cyc + 1;
      for (int k = 0; k <= WIDTH + 1; k++) begin
        e_gnt[(cyc+k)%RING] = '0; e_val[(cyc+k)%RING] = 1'b0;
        e_bit[(cyc+k)%RING] = 1'b0; e_done[(cyc+k)%RING] = 1'b0;
      end
    end else if (armed && cyc >= free_edge && bus.w_req != '0) begin
      m_win = -1;
      for (int o = 0; o < NREQ; o++) begin
        m_j = (m_ptr + o) % NREQ;
        if (m_win < 0 && bus.w_req[m_j]) m_win = m_j;
      end
      m_word = bus.w_data[m_win*WIDTH +: WIDTH];
      e_gnt[cyc%RING] = NREQ'(1) << m_win;
      for (int k = 0; k < WIDTH; k++) begin
        e_val[(cyc+k)%RING] = 1'b1;
        e_bit[(cyc+k)%RING] = bit_k(m_word, k);
      end
      e_done[(cyc+WIDTH)%RING] = 1'b1;
      free_edge = cyc + WIDTH + 1;
      m_ptr     = (m_win + 1) % NREQ;
    end
    #1;
    if (armed) begin
      act_v = {bus.w_gnt, bus.w_busy, bus.w_valid, bus.w_sout} == '0 ? 5'd0 : 5'd0;
      act_v = {bus.w_gnt[1], bus.w_gnt[0], bus.w_valid, bus.w_sout, bus.w_done};
      exp_v = {e_gnt[cyc%RING][1], e_gnt[cyc%RING][0], e_val[cyc%RING],
               e_bit[cyc%RING], e_done[cyc%RING]};
      checks = checks + 1;
      if (act_v !== exp_v || bus.w_busy !== e_val[cyc%RING]) begin
        errors = errors + 1;
        $display("FAIL model cyc %0d {gnt,valid,sout,done} got %b busy %b want %b busy %b",
                 cyc, act_v, bus.w_busy, exp_v, e_val[cyc%RING]);
      end
      e_gnt[cyc%RING] = '0; e_val[cyc%RING] = 1'b0;
      e_bit[cyc%RING] = 1'b0; e_done[cyc%RING] = 1'b0;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.w_req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits for a grant, checks it, collects the serial bits and the done cycle.
  task automatic run_xfer(input string name, input logic [NREQ-1:0] egnt,
                          input logic [WIDTH-1:0] lit_bits, input bit keep,
                          input logic [NREQ-1:0] rise, input int exp_wait);
    int n;
    logic [WIDTH-1:0] bits;
    int nval;
    n = 0;
    nval = 0;
    bits = '0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.w_gnt == '0 && n < 20);
    if (bus.w_gnt == '0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s grant timeout got 0 want %b", name, egnt);
      return;
    end
    if (exp_wait > 0) check({name, " wait"}, n, exp_wait);
    check({name, " gnt"}, int'(bus.w_gnt), int'(egnt));
    for (int k = 0; k < WIDTH; k++) begin
      if (k > 0) @(negedge clk);
      bits[k] = bus.w_sout;
      if (bus.w_valid === 1'b1) nval++;
      if (k == 0 && !keep) bus.w_req = bus.w_req & ~bus.w_gnt;
      if (k == 1) bus.w_req = bus.w_req | rise;
    end
    check({name, " bits"}, int'(bits), int'(lit_bits));
    check({name, " valid"}, nval, WIDTH);
    @(negedge clk);
    check({name, " done"}, int'({bus.w_done, bus.w_valid, bus.w_busy}), 4);
  endtask

  // Expected serial sequence as bits[k] = k-th bit on the wire.
  function automatic logic [WIDTH-1:0] wire_seq(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] s;
    for (int k = 0; k < WIDTH; k++) s[k] = bit_k(w, k);
    return s;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bus.w_req  = '0;
    bus.w_data = '0;
    rst = 1'b1;

    // 1: single request, word0 = 1011 -> wire 1,1,0,1 (LSB first)
    do_reset();
    bus.w_data[0 +: WIDTH] = 4'b1011;
    bus.w_req = 2'b01;
`ifdef M_SHIFT_SCHED_MSB_FIRST_EN
    run_xfer("t1", 2'b01, 4'b1101, 1'b0, 2'b00, 0);   // wire 1,0,1,1
`else
    run_xfer("t1", 2'b01, 4'b1011, 1'b0, 2'b00, 0);   // wire 1,1,0,1
`endif

    // 2: simultaneous requests after reset, A then 5, one idle gap
    do_reset();
    bus.w_data = {4'h5, 4'hA};
    bus.w_req  = 2'b11;
    run_xfer("t2a", 2'b01, wire_seq(4'hA), 1'b0, 2'b00, 0);
    run_xfer("t2b", 2'b10, wire_seq(4'h5), 1'b0, 2'b00, 1);

    // 4: reset during bit 2 drops the transfer
    bus.w_data = {4'h3, 4'hE};
    bus.w_req  = 2'b01;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.w_gnt == '0 && n < 20);
    check("t4 gnt", int'(bus.w_gnt), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.w_req = '0;
    @(negedge clk);
    check("t4 after rst", int'({bus.w_valid, bus.w_sout, bus.w_busy, bus.w_done}), 0);
    rst = 1'b0;
    @(negedge clk);
    check("t4 no done", int'(bus.w_done), 0);
    bus.w_req = 2'b10;
    run_xfer("t4b", 2'b10, wire_seq(4'h3), 1'b0, 2'b00, 0);
    bus.w_req = 2'b01;
    run_xfer("t4c", 2'b01, wire_seq(4'hE), 1'b0, 2'b00, 1);

    // 5: requester 1 rises mid-transfer and is served right after done
    bus.w_data = {4'h6, 4'h9};
    bus.w_req  = 2'b01;
    run_xfer("t5a", 2'b01, wire_seq(4'h9), 1'b0, 2'b10, 0);
    run_xfer("t5b", 2'b10, wire_seq(4'h6), 1'b0, 2'b00, 1);

    // 3: both held continuously -> 01,10,01,10 every WIDTH+1 cycles
    bus.w_data = {4'hC, 4'h2};
    bus.w_req  = 2'b11;
    run_xfer("t3a", 2'b01, wire_seq(4'h2), 1'b1, 2'b00, 1);
    run_xfer("t3b", 2'b10, wire_seq(4'hC), 1'b1, 2'b00, 1);
    run_xfer("t3c", 2'b01, wire_seq(4'h2), 1'b1, 2'b00, 1);
    bus.w_req = 2'b11;
    run_xfer("t3d", 2'b10, wire_seq(4'hC), 1'b1, 2'b00, 1);
    bus.w_req = '0;

    // random traffic, checked by the timeline model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 249) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.w_req[i]) begin
          if (bus.w_gnt[i]) begin
            if ($urandom_range(0, 1) == 0) bus.w_req[i] = 1'b0;
            else bus.w_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
          end else if ($urandom_range(0, 29) == 0) begin
            bus.w_req[i] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          bus.w_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
          bus.w_req[i] = 1'b1;
        end
      end
    end
    rst = 1'b0;
    bus.w_req = '0;
    repeat (WIDTH + 3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
